// File: rtl/instr_mem_pkg.sv
// Shared types for the banked instruction memory wrapper.
// Response source tags, scheduler slot layout, ROM region helpers.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RAM,
        SRC_ROM,
        SRC_ERR
    } resp_src_e;

    localparam int unsigned BANK_IDX_W = 3;

    typedef struct packed {
        resp_src_e             src;
        logic [BANK_IDX_W-1:0] bank;
    } resp_slot_t;

    localparam logic [15:0] ROM_TAG = 16'hB007;

    // ROM region base: the word address whose MSB alone is set.
    function automatic int unsigned rom_base(input int unsigned aw);
        return 32'd1 << (aw - 1);
    endfunction

    // Boot ROM contents: tag in the upper half, word offset below.
    function automatic logic [31:0] rom_word(input logic [15:0] off);
        return {ROM_TAG, off};
    endfunction

endpackage

// File: rtl/instr_ram_bank.sv
// Single-port 32-bit RAM bank with byte enables and a registered read.
// Ports: clk, en, we, be, row, wdata, bypass_en, rdata.
module instr_ram_bank #(
    parameter int unsigned ROWS  = 16384,
    parameter int unsigned ROW_W = 14
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [ROW_W-1:0] row,
    input  logic [31:0]      wdata,
    input  logic             bypass_en,
    output logic [31:0]      rdata
);

    logic [31:0] mem [ROWS];
    logic [31:0] wmask;

    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    // Bypass forwards the write bus onto the read port (test mode).
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= (mem[row] & ~wmask) | (wdata & wmask);
            end
            rdata <= bypass_en ? wdata : mem[row];
        end
    end

endmodule

// File: rtl/instr_resp_sched.sv
// In-order response scheduler: slot shift register plus grant logic.
// Ports: clk, rst_n, req_i/src_i/bank_i in, gnt_o, rsp_valid_o/rsp_src_o/rsp_bank_o out.
module instr_resp_sched
    import instr_mem_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [1:0]            src_i,
    input  logic [BANK_IDX_W-1:0] bank_i,
    output logic                  gnt_o,
    output logic                  rsp_valid_o,
    output logic [1:0]            rsp_src_o,
    output logic [BANK_IDX_W-1:0] rsp_bank_o
);

    logic [LAT:1]       vld_q, vld_sh, vld_d;
    resp_slot_t [LAT:1] slot_q, slot_sh, slot_d;
    resp_slot_t         in_slot;
    logic               is_rom;
    logic               busy;

    assign in_slot = '{src: resp_src_e'(src_i), bank: bank_i};
    assign is_rom  = resp_src_e'(src_i) == SRC_ROM;

    // Anything in slots 2.. lands in slot 1 or later after the shift,
    // so a 1-cycle response would overtake or collide with it.
    if (LAT > 1) begin : g_multi
        assign busy    = |vld_q[LAT:2];
        assign vld_sh  = {1'b0, vld_q[LAT:2]};
        assign slot_sh = {resp_slot_t'('0), slot_q[LAT:2]};
    end else begin : g_single
        assign busy    = 1'b0;
        assign vld_sh  = 1'b0;
        assign slot_sh = '0;
    end

    assign gnt_o = req_i & (is_rom | ~busy);

    always_comb begin
        vld_d  = vld_sh;
        slot_d = slot_sh;
        if (gnt_o) begin
            if (is_rom) begin
                vld_d[LAT]  = 1'b1;
                slot_d[LAT] = in_slot;
            end else begin
                vld_d[1]  = 1'b1;
                slot_d[1] = in_slot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            slot_q <= '0;
        end else begin
            vld_q  <= vld_d;
            slot_q <= slot_d;
        end
    end

    assign rsp_valid_o = vld_q[1];
    assign rsp_src_o   = slot_q[1].src;
    assign rsp_bank_o  = slot_q[1].bank;

endmodule

// File: rtl/instr_mem_bank_wrap.sv
// Instruction memory wrapper: interleaved RAM banks, boot ROM, req/gnt/rvalid.
// Ports: clk, rst_n, req_i, gnt_o, addr_i, we_i, be_i, wdata_i,
//        rvalid_o, rdata_o, err_o, bypass_en_i.
module instr_mem_bank_wrap
    import instr_mem_pkg::*;
#(
    parameter int unsigned RAM_SIZE    = 32768,
    parameter int unsigned N_BANKS     = 2,
    parameter int unsigned ROM_SIZE    = 512,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned ADDR_WIDTH  = $clog2(RAM_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    input  logic                  bypass_en_i
);

    localparam int unsigned BANK_BITS = $clog2(N_BANKS);
    localparam int unsigned ROWS      = RAM_SIZE / N_BANKS;
    localparam int unsigned ROW_W     = ADDR_WIDTH - 1 - BANK_BITS;
    localparam int unsigned LAT       = ROM_LATENCY;

    localparam logic [ADDR_WIDTH-1:0] ROM_BASE =
        ADDR_WIDTH'(rom_base(ADDR_WIDTH));

    logic                  in_rom_region;
    logic                  rom_hit;
    logic [ADDR_WIDTH-1:0] rom_off;
    logic [ROW_W-1:0]      row;
    logic [BANK_IDX_W-1:0] bank_sel;
    resp_src_e             req_src;

    assign in_rom_region = addr_i[ADDR_WIDTH-1];
    assign rom_off       = addr_i - ROM_BASE;
    assign rom_hit       = in_rom_region && !we_i &&
                           (rom_off < ADDR_WIDTH'(ROM_SIZE));
    assign row           = addr_i[ADDR_WIDTH-2:BANK_BITS];

    if (N_BANKS > 1) begin : g_bank_idx
        assign bank_sel = BANK_IDX_W'(addr_i[BANK_BITS-1:0]);
    end else begin : g_one_bank
        assign bank_sel = '0;
    end

    // RAM writes are tagged SRC_NONE: they answer with zero data.
    always_comb begin
        unique case (1'b1)
            !in_rom_region: req_src = we_i ? SRC_NONE : SRC_RAM;
            rom_hit:        req_src = SRC_ROM;
            default:        req_src = SRC_ERR;
        endcase
    end

    logic                  rsp_valid;
    logic [1:0]            rsp_src_raw;
    resp_src_e             rsp_src;
    logic [BANK_IDX_W-1:0] rsp_bank;

    instr_resp_sched #(
        .LAT (LAT)
    ) u_sched (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .src_i       (req_src),
        .bank_i      (bank_sel),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid),
        .rsp_src_o   (rsp_src_raw),
        .rsp_bank_o  (rsp_bank)
    );

    assign rsp_src = resp_src_e'(rsp_src_raw);

    logic                      ram_acc;
    logic                      rom_en;
    logic [N_BANKS-1:0]        bank_en;
    logic [N_BANKS-1:0][31:0]  bank_rdata;
    logic [N_BANKS:0][31:0]    ram_or;

    assign ram_acc   = gnt_o && !in_rom_region;
    assign rom_en    = gnt_o && (req_src == SRC_ROM);
    assign ram_or[0] = '0;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        assign bank_en[b] = ram_acc && (bank_sel == BANK_IDX_W'(b));

        instr_ram_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk       (clk),
            .en        (bank_en[b]),
            .we        (we_i),
            .be        (be_i),
            .row       (row),
            .wdata     (wdata_i),
            .bypass_en (bypass_en_i),
            .rdata     (bank_rdata[b])
        );

        assign ram_or[b+1] = ram_or[b] |
            ((rsp_bank == BANK_IDX_W'(b)) ? bank_rdata[b] : 32'h0);
    end

    // ROM read data travels alongside its slot so overlapping
    // ROM reads each keep their own word.
    logic [LAT:1][31:0] rom_pipe_q, rom_pipe_sh, rom_pipe_d;

    if (LAT > 1) begin : g_rom_shift
        assign rom_pipe_sh = {32'h0, rom_pipe_q[LAT:2]};
    end else begin : g_rom_flat
        assign rom_pipe_sh = '0;
    end

    always_comb begin
        rom_pipe_d = rom_pipe_sh;
        if (rom_en) begin
            rom_pipe_d[LAT] = rom_word(16'(rom_off));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_pipe_q <= '0;
        end else begin
            rom_pipe_q <= rom_pipe_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rsp_valid) begin
            unique case (rsp_src)
                SRC_RAM: rdata_o = ram_or[N_BANKS];
                SRC_ROM: rdata_o = rom_pipe_q[1];
                default: rdata_o = '0;
            endcase
        end
    end

    assign rvalid_o = rsp_valid;
    assign err_o    = rsp_valid && (rsp_src == SRC_ERR);

endmodule

// File: tb/tb_instr_mem_bank_wrap.sv
// Self-checking bench for instr_mem_bank_wrap (default parameters).
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_mem_bank_wrap;

    localparam int LAT  = 2;
    localparam int ROMB = 'h8000;
    localparam int ROMN = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic        bypass_en_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ram_m [int];

    instr_mem_bank_wrap dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .bypass_en_i (bypass_en_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // 0 = RAM, 1 = ROM read, 2 = error
    function automatic int kind(input logic [15:0] a, input logic w);
        int ai;
        ai = int'(a);
        if (ai < ROMB) return 0;
        if (w || (ai - ROMB) >= ROMN) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    logic        m_rv, m_e, m_g, m_blk;
    logic [31:0] m_d;
    logic [1:0]  m_ben;
    int          m_k;
    rsp_t        m_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_rvalid", 32'(rvalid_o), 32'h0);
            chk("rst_rdata", rdata_o, 32'h0);
            chk("rst_err", 32'(err_o), 32'h0);
        end else begin
            m_rv = 1'b0;
            m_d  = '0;
            m_e  = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                m_rv = 1'b1;
                m_d  = exp_q[0].data;
                m_e  = exp_q[0].err;
                void'(exp_q.pop_front());
            end
            chk("rvalid", 32'(rvalid_o), 32'(m_rv));
            chk("rdata", rdata_o, m_d);
            if (m_rv) chk("err", 32'(err_o), 32'(m_e));

            m_k   = kind(addr_i, we_i);
            m_blk = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].due > cyc) m_blk = 1'b1;
            m_g = req_i && (m_k == 1 || !m_blk);
            chk("gnt", 32'(gnt_o), 32'(m_g));

            m_ben = (m_g && m_k == 0) ? (2'b01 << addr_i[0]) : 2'b00;
            chk("bank_en", 32'(dut.bank_en), 32'(m_ben));
            chk("rom_en", 32'(dut.rom_en), 32'(m_g && m_k == 1));

            if (m_g) begin
                m_r.due  = cyc + ((m_k == 1) ? LAT : 1);
                m_r.err  = (m_k == 2);
                m_r.data = '0;
                if (m_k == 1) begin
                    m_r.data = 32'hB007_0000 | 32'(int'(addr_i) - ROMB);
                end else if (m_k == 0) begin
                    if (we_i) begin
                        ram_m[int'(addr_i)] = merge(
                            ram_m.exists(int'(addr_i)) ? ram_m[int'(addr_i)] : 32'h0,
                            wdata_i, be_i);
                    end else begin
                        m_r.data = ram_m[int'(addr_i)];
                    end
                end
                exp_q.push_back(m_r);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d,
                         output int waits);
        logic g;
        waits   = 0;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = d;
        do begin
            @(negedge clk);
            g = gnt_o;
            waits++;
            @(posedge clk);
            #1;
        end while (!g && waits < 8);
        if (!g) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout addr %h: no gnt in %0d cycles, want gnt",
                     a, waits);
        end
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_rsp(input string nm, input int lag,
                              input logic [31:0] d, input logic e);
        repeat (lag) @(posedge clk);
        @(negedge clk);
        chk({nm, "_rvalid"}, 32'(rvalid_o), 32'h1);
        chk({nm, "_rdata"}, rdata_o, d);
        chk({nm, "_err"}, 32'(err_o), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [15:0] a;
        logic [31:0] d;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rvalid_lit", 32'(rvalid_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        issue(16'h0004, 1'b1, 4'hF, 32'hDEADBEEF, w);
        chk("wr4_wait", w, 1);
        expect_rsp("wr4", 0, 32'h0, 1'b0);
        issue(16'h0004, 1'b0, 4'hF, 32'h0, w);
        chk("rd4_wait", w, 1);
        expect_rsp("rd4", 0, 32'hDEADBEEF, 1'b0);
        issue(16'h0005, 1'b1, 4'hF, 32'h12345678, w);
        issue(16'h0006, 1'b1, 4'hF, 32'hCAFEF00D, w);
        idle(1);

        issue(16'h0004, 1'b0, 4'hF, 32'h0, w);
        chk("b2b_0_wait", w, 1);
        issue(16'h0005, 1'b0, 4'hF, 32'h0, w);
        chk("b2b_1_wait", w, 1);
        issue(16'h0006, 1'b0, 4'hF, 32'h0, w);
        chk("b2b_2_wait", w, 1);
        expect_rsp("b2b_last", 0, 32'hCAFEF00D, 1'b0);

        issue(16'h8000, 1'b0, 4'hF, 32'h0, w);
        issue(16'h0004, 1'b0, 4'hF, 32'h0, w);
        chk("ram_after_rom_wait", w, 2);
        idle(3);

        issue(16'h8000, 1'b0, 4'hF, 32'h0, w);
        chk("rom0_wait", w, 1);
        issue(16'h8001, 1'b0, 4'hF, 32'h0, w);
        chk("rom1_wait", w, 1);
        expect_rsp("rom1", 1, 32'hB0070001, 1'b0);

        issue(16'h8200, 1'b0, 4'hF, 32'h0, w);
        expect_rsp("err_8200", 0, 32'h0, 1'b1);
        issue(16'h8000, 1'b1, 4'hF, 32'h55555555, w);
        expect_rsp("err_wr_rom", 0, 32'h0, 1'b1);
        issue(16'h8000, 1'b0, 4'hF, 32'h0, w);
        expect_rsp("rom0_again", 1, 32'hB0070000, 1'b0);

        issue(16'h0004, 1'b1, 4'b0101, 32'h11223344, w);
        issue(16'h0004, 1'b0, 4'hF, 32'h0, w);
        expect_rsp("rd4_partial", 0, 32'hDE22BE44, 1'b0);

        issue(16'h8003, 1'b0, 4'hF, 32'h0, w);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        issue(16'h0004, 1'b0, 4'hF, 32'h0, w);
        expect_rsp("rd4_after_rst", 0, 32'hDE22BE44, 1'b0);

        for (int i = 0; i < 32; i++) begin
            a = (i < 16) ? 16'(i) : 16'(32'h7FF0 + i - 16);
            issue(a, 1'b1, 4'hF, $urandom, w);
        end

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15))
                                                : 16'($urandom_range(32'h7FF0, 32'h7FFF));
            end else if (r < 8) begin
                a = 16'(ROMB + $urandom_range(0, 15));
            end else begin
                a = 16'(ROMB + $urandom_range(508, 515));
            end
            d = $urandom;
            issue(a, ($urandom_range(0, 2) == 0), 4'($urandom), d, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("drain", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_bank_wrap.md
Name: instr_mem_bank_wrap

Overview:
- Second-generation instruction memory wrapper that sits between the core instruction/debug port and the on-chip memories.
- Splits the RAM region into N_BANKS word-interleaved single-port banks and maps a boot ROM region with configurable read latency.
- Adds a req/gnt/rvalid handshake with in-order responses and an error response for unmapped or illegal accesses.

Parameters:
- RAM_SIZE, 32768, total RAM words; must be a multiple of N_BANKS.
- N_BANKS, 2, number of interleaved RAM banks; power of two, 1..8.
- ROM_SIZE, 512, boot ROM words.
- ROM_LATENCY, 2, ROM read latency in cycles, 1..3.
- ADDR_WIDTH, $clog2(RAM_SIZE)+1, word-address width; the MSB selects the ROM region.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  access request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  ADDR_WIDTH  word address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data; 0 when rvalid_o=0, on writes, and on errors
- err_o  out  1  error flag, qualified by rvalid_o
- bypass_en_i  in  1  passed unchanged to every RAM bank

Behaviour:
- Decode (combinational, on addr_i):
  - MSB=0: RAM. Bank = addr_i[log2(N_BANKS)-1:0]; row = remaining low bits.
  - MSB=1 and offset < ROM_SIZE: ROM.
  - MSB=1 and offset >= ROM_SIZE: ERR.
  - Any write to the ROM region: ERR.
- Response latency:
  - RAM read/write and ERR: 1 cycle.
  - ROM read: ROM_LATENCY cycles.
  - Every granted request yields exactly one rvalid_o pulse. Writes return rvalid_o=1, err_o=0, rdata_o=0.
- Response scheduler: shift register of slots 1..ROM_LATENCY, each holding {valid, src, bank}. Shifts toward slot 1 every cycle; slot 1 drives the response mux.
- Grant rule (combinational, evaluated against the post-shift occupancy):
  - ROM request: always granted; enters slot ROM_LATENCY.
  - RAM or ERR request: granted only if slots 2..ROM_LATENCY are empty, so responses stay in order.
  - Otherwise gnt_o=0. The requester holds req_i and addr_i stable until granted.
- Memory enables:
  - Exactly one bank enable per granted RAM access; the ROM enable only for a granted ROM read.
  - No memory enable for ERR or ungranted requests.
- Response mux: selects bank[slot1.bank], ROM, or zero using the registered slot tag, never the live address.
- Only one request per cycle. A request is granted in the same cycle as a response for an earlier request.
- ROM_LATENCY=1: degenerates to single-cycle, always-grant behaviour.
- Reset values: gnt_o follows the grant rule; rvalid_o=0, rdata_o=0, err_o=0; all slots invalid.
- Reset mid-operation: outstanding responses are discarded with no rvalid_o after deassertion, and memory contents are not touched.
- req_i=0: no state change apart from the shift.

Decomposition:
- Package instr_mem_pkg holds:
  - resp_src_e enum {SRC_NONE, SRC_RAM, SRC_ROM, SRC_ERR}
  - resp_slot_t struct {src, bank index}
  - ROM region base constant
- Sub-module instr_resp_sched: owns the slot shift register, grant computation and slot-1 outputs.
- Top level: decode, bank/ROM instantiation, response mux.

Test Plan (RAM_SIZE=32768, N_BANKS=2, ROM_SIZE=512, ROM_LATENCY=2; ROM base 0x8000):
- Write 0xDEADBEEF to 0x0004, be=0xF, then read 0x0004 -> gnt same cycle, rvalid 1 cycle later, rdata=0xDEADBEEF; bank 0 enable only; next, address 0x0005 enables bank 1 only.
- Back-to-back reads 0x0004, 0x0005, 0x0006 -> all granted, three consecutive rvalid pulses, data in order.
- ROM read 0x8000 followed immediately by RAM read 0x0004 -> RAM gnt_o=0 for 1 cycle; rvalids arrive ROM word first, then RAM word; no overlap.
- ROM reads 0x8000, 0x8001 back-to-back -> both granted, rvalid on cycles +2 and +3.
- Read 0x8200 (offset 512) and write 0x8000 -> rvalid with err_o=1, rdata=0, no memory enable; a read of 0x8000 still returns original ROM data.
- Assert rst_n=0 one cycle after a granted ROM read -> no rvalid after release; rvalid_o=0, err_o=0, rdata_o=0 during and after reset.
